// File: rtl/cmd_pkg.sv
// Shared types and constants for the command dispatcher and its helpers.
package cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_SEND    = 3'd4,
    ST_TX_LOW  = 3'd5,
    ST_TX_HIGH = 3'd6,
    ST_FIN     = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    STATUS_NONE    = 2'b00,
    STATUS_OK      = 2'b01,
    STATUS_INVALID = 2'b10,
    STATUS_TIMEOUT = 2'b11
  } status_e;

  localparam logic [7:0] CHAR_BASE     = 8'h30;
  localparam logic [7:0] REPLY_OK      = 8'h4B;
  localparam logic [7:0] REPLY_INVALID = 8'h3F;
  localparam logic [7:0] REPLY_TIMEOUT = 8'h54;

  // True when the byte names one of the n handlers ('0' .. '0'+n-1).
  function automatic logic cmd_valid(input logic [7:0] b, input int unsigned n);
    return (b >= CHAR_BASE) && (b < (CHAR_BASE + 8'(n)));
  endfunction

endpackage

// File: rtl/timeout_cnt.sv
// Clear/enable cycle counter; tc_o flags the last allowed cycle (TIMEOUT-1).
module timeout_cnt #(
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cmd_dispatcher.sv
// Decodes a buffered ASCII command, starts and supervises one handler,
// then replies one status byte over the UART and signals end-of-FSM.
module cmd_dispatcher
  import cmd_pkg::*;
#(
  parameter int unsigned N_CMD   = 4,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stfsm_i,
  input  logic [7:0]       cmd_i,
  output logic [N_CMD-1:0] start_o,
  input  logic [N_CMD-1:0] done_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_start_o,
  input  logic             tx_eot_i,
  output logic             eofsm_o,
  output logic             busy_o,
  output logic [1:0]       status_o
);

  localparam int unsigned IDX_W = (N_CMD > 1) ? $clog2(N_CMD) : 1;

  state_e           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  status_e          status_q, status_d;
  logic             tc;

  timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state_q == ST_START),
    .en_i  (state_q == ST_WAIT),
    .tc_o  (tc)
  );

  // Next state; reply and status only change on the way into SEND.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    status_d  = status_q;
    case (state_q)
      ST_IDLE: begin
        if (stfsm_i) begin
          cmd_d   = cmd_i;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cmd_valid(cmd_q, N_CMD)) begin
          idx_d   = IDX_W'(cmd_q - CHAR_BASE);
          state_d = ST_START;
        end else begin
          tx_data_d = REPLY_INVALID;
          status_d  = STATUS_INVALID;
          state_d   = ST_SEND;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_i[idx_q]) begin
          tx_data_d = REPLY_OK;
          status_d  = STATUS_OK;
          state_d   = ST_SEND;
        end else if (tc) begin
          tx_data_d = REPLY_TIMEOUT;
          status_d  = STATUS_TIMEOUT;
          state_d   = ST_SEND;
        end
      end
      ST_SEND:    state_d = ST_TX_LOW;
      ST_TX_LOW:  if (!tx_eot_i) state_d = ST_TX_HIGH;
      ST_TX_HIGH: if (tx_eot_i) state_d = ST_FIN;
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      idx_q     <= '0;
      tx_data_q <= '0;
      status_q  <= STATUS_NONE;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      status_q  <= status_d;
    end
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    start_o = '0;
    if (state_q == ST_START) begin
      start_o[idx_q] = 1'b1;
    end
  end

  assign tx_start_o = (state_q == ST_SEND);
  assign eofsm_o    = (state_q == ST_FIN);
  assign busy_o     = (state_q != ST_IDLE);
  assign tx_data_o  = tx_data_q;
  assign status_o   = status_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed bench for cmd_dispatcher with N_CMD=4, TIMEOUT=16.
module tb_cmd_dispatcher;

  localparam int unsigned N_CMD   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             stfsm_i = 1'b0;
  logic [7:0]       cmd_i = 8'h00;
  logic [N_CMD-1:0] start_o;
  logic [N_CMD-1:0] done_i = '0;
  logic [7:0]       tx_data_o;
  logic             tx_start_o;
  logic             tx_eot_i = 1'b1;
  logic             eofsm_o;
  logic             busy_o;
  logic [1:0]       status_o;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int eof_cnt = 0;
  logic [N_CMD-1:0] last_start = '0;

  cmd_dispatcher #(
    .N_CMD  (N_CMD),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .stfsm_i   (stfsm_i),
    .cmd_i     (cmd_i),
    .start_o   (start_o),
    .done_i    (done_i),
    .tx_data_o (tx_data_o),
    .tx_start_o(tx_start_o),
    .tx_eot_i  (tx_eot_i),
    .eofsm_o   (eofsm_o),
    .busy_o    (busy_o),
    .status_o  (status_o)
  );

  always #5 clk_i = ~clk_i;

  // Pulse monitor sampled on the inactive edge.
  always @(negedge clk_i) begin
    if (start_o != '0) begin
      start_cnt  = start_cnt + 1;
      last_start = start_o;
    end
    if (eofsm_o) eof_cnt = eof_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Pulse stfsm_i for one cycle and advance into DECODE.
  task automatic issue(input logic [7:0] cmd);
    cmd_i   = cmd;
    stfsm_i = 1'b1;
    tick();
    stfsm_i = 1'b0;
  endtask

  task automatic wait_tx(input int bound, output int n);
    n = 0;
    while (!tx_start_o && n < bound) begin
      tick();
      n++;
    end
    if (!tx_start_o) check("tx_start_wait_expired", 32'd0, 32'd1);
  endtask

  // Called in the SEND cycle: UART drops eot for low_cycles, then expect one eofsm.
  task automatic uart_reply(input int low_cycles);
    int eof0;
    eof0 = eof_cnt;
    tick();
    tx_eot_i = 1'b0;
    repeat (low_cycles) tick();
    check("eofsm_early", 32'(eofsm_o), 32'd0);
    tx_eot_i = 1'b1;
    tick();
    check("eofsm_pulse", 32'(eofsm_o), 32'd1);
    tick();
    check("idle_after_fin", {30'd0, busy_o, eofsm_o}, 32'd0);
    check("eofsm_count", 32'(eof_cnt - eof0), 32'd1);
  endtask

  initial begin
    int n;
    int s0;

    // Reset values
    repeat (2) tick();
    check("rst_start", 32'(start_o), 32'd0);
    check("rst_txdata", 32'(tx_data_o), 32'd0);
    check("rst_flags", {29'd0, tx_start_o, eofsm_o, busy_o}, 32'd0);
    check("rst_status", 32'(status_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Valid command '2', done 5 cycles after start_o
    s0 = start_cnt;
    issue(8'h32);
    check("c2_busy_decode", 32'(busy_o), 32'd1);
    tick();
    check("c2_start", 32'(start_o), 32'h4);
    repeat (4) tick();
    done_i = 4'b0100;
    tick();
    done_i = '0;
    check("c2_tx_start", 32'(tx_start_o), 32'd1);
    check("c2_tx_data", 32'(tx_data_o), 32'h4B);
    check("c2_status", 32'(status_o), 32'd1);
    uart_reply(10);
    check("c2_start_once", 32'(start_cnt - s0), 32'd1);

    // Invalid command 'A'
    s0 = start_cnt;
    issue(8'h41);
    tick();
    check("inv_tx_start", 32'(tx_start_o), 32'd1);
    check("inv_tx_data", 32'(tx_data_o), 32'h3F);
    check("inv_status", 32'(status_o), 32'd2);
    uart_reply(3);
    check("inv_no_start", 32'(start_cnt - s0), 32'd0);

    // Command '1' times out; a stray done_i[3] is ignored
    issue(8'h31);
    tick();
    check("c1_start", 32'(start_o), 32'h2);
    tick();
    repeat (4) tick();
    done_i = 4'b1000;
    tick();
    done_i = '0;
    wait_tx(40, n);
    check("to_latency", 32'(n + 5), 32'(TIMEOUT));
    check("to_tx_data", 32'(tx_data_o), 32'h54);
    check("to_status", 32'(status_o), 32'd3);
    uart_reply(2);

    // done_i[1] coincident with terminal count: done wins
    issue(8'h31);
    repeat (2) tick();
    repeat (TIMEOUT - 1) tick();
    done_i = 4'b0010;
    tick();
    done_i = '0;
    check("tc_done_tx_start", 32'(tx_start_o), 32'd1);
    check("tc_done_tx_data", 32'(tx_data_o), 32'h4B);
    check("tc_done_status", 32'(status_o), 32'd1);
    uart_reply(1);

    // Reset in WAIT
    issue(8'h32);
    repeat (4) tick();
    check("wait_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("rst_wait_flags", {28'd0, start_o}, 32'd0);
    check("rst_wait_busy", {30'd0, busy_o, tx_start_o}, 32'd0);
    check("rst_wait_status", 32'(status_o), 32'd0);
    check("rst_wait_tx_data", 32'(tx_data_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();

    // Normal command after reset; stfsm_i while busy is ignored
    s0 = start_cnt;
    issue(8'h30);
    tick();
    check("c0_start", 32'(start_o), 32'h1);
    tick();
    issue(8'h33);
    tick();
    done_i = 4'b0001;
    tick();
    done_i = '0;
    check("c0_tx_start", 32'(tx_start_o), 32'd1);
    check("c0_tx_data", 32'(tx_data_o), 32'h4B);
    uart_reply(4);
    repeat (4) tick();
    check("busy_stfsm_ignored", 32'(start_cnt - s0), 32'd1);
    check("c0_last_start", 32'(last_start), 32'h1);
    check("idle_stays", 32'(busy_o), 32'd0);

    // Reset in TX_HIGH: no eofsm
    s0 = eof_cnt;
    issue(8'h39);
    tick();
    check("inv2_tx_start", 32'(tx_start_o), 32'd1);
    tick();
    tx_eot_i = 1'b0;
    repeat (3) tick();
    check("txh_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("rst_txh_flags", {29'd0, tx_start_o, eofsm_o, busy_o}, 32'd0);
    check("rst_txh_status", 32'(status_o), 32'd0);
    check("rst_txh_tx_data", 32'(tx_data_o), 32'd0);
    tx_eot_i = 1'b1;
    tick();
    rst_i = 1'b0;
    repeat (3) tick();
    check("rst_txh_no_eofsm", 32'(eof_cnt - s0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_dispatcher.md
# cmd_dispatcher

Command dispatcher between the terminal control FSM and the per-command handler FSMs. On a start pulse it decodes the buffered ASCII command byte, one-hot starts the matching handler and supervises it with a timeout. It then sends a one-byte status reply through the shared UART transmitter and returns an end-of-FSM pulse to the terminal FSM. It is the block that drives the terminal FSM's `eofsm_i` input and consumes its `stfsm_o` output.

## Interface
- `N_CMD`, default 4: number of handlers; valid commands are ASCII `'0'` to `'0'+N_CMD-1` (8'h30 + k), with N_CMD ≤ 10.
- `TIMEOUT`, default 1_000_000: clock cycles allowed in WAIT before the command is declared timed out; minimum 2.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `stfsm_i`, in, 1: one-cycle start pulse from the terminal FSM.
- `cmd_i`, in, 8: buffered command byte; only the value sampled in IDLE when `stfsm_i`=1 is used.
- `start_o`, out, N_CMD: one-hot, one-cycle start pulse to handler k.
- `done_i`, in, N_CMD: done pulses from the handlers.
- `tx_data_o`, out, 8: reply byte to the UART TX.
- `tx_start_o`, out, 1: one-cycle transmit request.
- `tx_eot_i`, in, 1: UART TX end-of-transmission; high when idle, low while sending.
- `eofsm_o`, out, 1: one-cycle completion pulse to the terminal FSM.
- `busy_o`, out, 1: high in every state except IDLE.
- `status_o`, out, 2: result of the last command; 00 none, 01 ok, 10 invalid, 11 timeout.

## Operation
- Reset values: all outputs 0, state IDLE, timeout counter 0, latched index 0.
- IDLE: when `stfsm_i`=1, latch `cmd_i` and go to DECODE. The terminal FSM only pulses `stfsm_i` after an end-of-FSM handshake, so `stfsm_i` outside IDLE is ignored.
- DECODE:
  - If the byte is in range, compute k = byte − 8'h30, latch k, go to START.
  - Otherwise set the reply to `'?'` (8'h3F) and status to 10, go to SEND.
- START: `start_o[k]`=1 for this single cycle; clear the counter; go to WAIT.
- WAIT: the counter increments every cycle.
  - `done_i[k]`=1: reply `'K'` (8'h4B), status 01, go to SEND.
  - Else, counter = TIMEOUT−1: reply `'T'` (8'h54), status 11, go to SEND.
  - `done_i` bits other than k are ignored.
- SEND: `tx_start_o`=1 for one cycle; `tx_data_o` holds the reply from entering SEND until the next reply is selected; go to TX_LOW.
- TX_LOW: wait for `tx_eot_i`=0, then go to TX_HIGH.
- TX_HIGH: wait for `tx_eot_i`=1, then go to FIN.
- FIN: `eofsm_o`=1 for one cycle; go to IDLE.
- Moore outputs decoded from state. The `status_o` and `tx_data_o` registers update at the transition into SEND.
- Unused state encodings go to IDLE.

## Timing
- `stfsm_i` at cycle t: DECODE at t+1, `start_o[k]` high at t+2, WAIT from t+3.
- Invalid command: `tx_start_o` high at t+2.
- `done_i[k]` at cycle w: `tx_start_o` at w+1.
- First WAIT cycle at cycle s with no done: the timeout transition is taken at s+TIMEOUT−1, so `tx_start_o` is at s+TIMEOUT.
- `done_i[k]` in the same cycle the counter hits TIMEOUT−1: done wins, reply `'K'`.
- `tx_eot_i` rise at cycle r in TX_HIGH: `eofsm_o` at r+1.
- Counter width is `$clog2(TIMEOUT+1)`. It never wraps, because it is cleared in START.
- `rst_i` mid-command: the FSM returns to IDLE asynchronously and all outputs drop to 0 at once. Handlers and the UART share `rst_i`; no reply is sent.

## Structure
- Shared package `cmd_pkg`: state encodings (IDLE, DECODE, START, WAIT, SEND, TX_LOW, TX_HIGH, FIN), reply characters `'K'`/`'?'`/`'T'`, status codes, and the base char 8'h30.
- Sub-module `timeout_cnt`: clear/enable counter with parameter TIMEOUT and a terminal-count output `tc_o`, asserted when count = TIMEOUT−1.
- Two-process FSM (combinational next-state/outputs plus registered state) and registered `tx_data_o`/`status_o`.

## Test plan
- N_CMD=4, TIMEOUT=16; `cmd_i`=8'h32, `stfsm_i` pulse, `done_i[2]` 5 cycles after `start_o`, UART model drops `tx_eot_i` for 10 cycles: `start_o`=4'b0100 exactly once, `tx_data_o`=8'h4B, `status_o`=01, then one `eofsm_o` pulse.
- `cmd_i`=8'h41: no `start_o`, `tx_data_o`=8'h3F, `status_o`=10, then `eofsm_o`.
- `cmd_i`=8'h31, no done: `tx_start_o` 16 cycles after the first WAIT cycle, `tx_data_o`=8'h54, `status_o`=11.
- `done_i[1]` coincident with terminal count: reply 8'h4B. Also, `done_i[3]` while waiting on handler 1: ignored, command still times out.
- `rst_i` asserted in WAIT and again in TX_HIGH: all outputs 0 immediately, `busy_o`=0. A new `stfsm_i` after reset is processed normally, and `stfsm_i` pulses while `busy_o`=1 have no effect.
